// File: rtl/fp16_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp16_adder: multi-cycle IEEE-754 binary16 adder, start/ready handshake.  |
// | Optional macro FP16_ROUND_NEAREST_EN: round-to-nearest-even (else trunc).|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fp16_adder #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   add,
    input  logic [EXP_W+MAN_W:0]   number1,
    input  logic [EXP_W+MAN_W:0]   number2,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   ready
);
    localparam int c_W  = EXP_W + MAN_W + 1;
    localparam int c_X  = MAN_W + 4;
    localparam int c_LZ = $clog2(c_X + 1);
    localparam int c_EW = EXP_W + 2;
    localparam logic [EXP_W-1:0]       c_EXP_INF  = EXP_W'(2 * BIAS + 1);
    localparam logic [c_W-1:0]         c_QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [c_EW-1:0] c_EXP_ZERO = '0;
    localparam logic signed [c_EW-1:0] c_EXP_OVF  = c_EW'(2 * BIAS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIGN  = 3'd1,
        S_ADDSUB = 3'd2,
        S_NORM   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state, w_next;
    logic [c_W-1:0]       r_a, r_b, r_special_val, r_result;
    logic [c_X-1:0]       r_big, r_small;
    logic [c_X:0]         r_sum;
    logic [EXP_W-1:0]     r_exp;
    logic                 r_sign, r_sub, r_special;

    // Operand unpack; exponent 0 flushes the operand to zero.
    logic                 w_a_sign, w_b_sign, w_a_zero, w_b_zero, w_swap;
    logic [EXP_W-1:0]     w_a_exp, w_b_exp, w_big_exp, w_small_exp, w_diff;
    logic [MAN_W-1:0]     w_a_frac, w_b_frac;
    logic [c_W-2:0]       w_a_mag, w_b_mag;
    logic [MAN_W:0]       w_a_man, w_b_man, w_big_man, w_small_man;
    logic [2*c_X-1:0]     w_wide;
    logic [c_X-1:0]       w_small_al;
    logic                 w_special;
    logic [c_W-1:0]       w_special_val;

    assign {w_a_sign, w_a_exp, w_a_frac} = r_a;
    assign {w_b_sign, w_b_exp, w_b_frac} = r_b;
    assign w_a_zero    = (w_a_exp == '0);
    assign w_b_zero    = (w_b_exp == '0);
    assign w_a_mag     = w_a_zero ? '0 : r_a[c_W-2:0];
    assign w_b_mag     = w_b_zero ? '0 : r_b[c_W-2:0];
    assign w_a_man     = w_a_zero ? '0 : {1'b1, w_a_frac};
    assign w_b_man     = w_b_zero ? '0 : {1'b1, w_b_frac};
    assign w_swap      = (w_b_mag > w_a_mag);
    assign w_big_man   = w_swap ? w_b_man : w_a_man;
    assign w_small_man = w_swap ? w_a_man : w_b_man;
    assign w_big_exp   = w_swap ? w_b_exp : w_a_exp;
    assign w_small_exp = w_swap ? w_a_exp : w_b_exp;
    assign w_diff      = w_big_exp - w_small_exp;
    assign w_wide      = {w_small_man, 3'b000, {c_X{1'b0}}} >> w_diff;
    // Everything shifted below the S position collapses into the sticky bit.
    assign w_small_al  = (w_diff >= EXP_W'(c_X)) ? {{(c_X-1){1'b0}}, |w_small_man}
                       : {w_wide[2*c_X-1:c_X+1], w_wide[c_X] | (|w_wide[c_X-1:0])};

    always_comb begin
        w_special     = 1'b1;
        w_special_val = '0;
        if ((w_a_exp == c_EXP_INF && w_a_frac != '0) || (w_b_exp == c_EXP_INF && w_b_frac != '0))
            w_special_val = c_QNAN;
        else if (w_a_exp == c_EXP_INF && w_b_exp == c_EXP_INF && w_a_sign != w_b_sign)
            w_special_val = c_QNAN;
        else if (w_a_exp == c_EXP_INF)
            w_special_val = r_a;
        else if (w_b_exp == c_EXP_INF)
            w_special_val = r_b;
        else if (w_a_zero && w_b_zero)
            w_special_val = {w_a_sign & w_b_sign, {(c_W-1){1'b0}}};
        else
            w_special = 1'b0;
    end

    logic [c_X:0] w_sum;
    assign w_sum = r_sub ? ({1'b0, r_big} - {1'b0, r_small}) : ({1'b0, r_big} + {1'b0, r_small});

    logic [c_LZ-1:0]        w_lzc;
    logic                   w_found;
    logic [c_X-1:0]         w_norm;
    logic [c_EW-1:0]        w_nexp;
    logic                   w_round_up;
    logic [MAN_W+1:0]       w_rnd;
    logic signed [c_EW-1:0] w_fexp;
    logic [MAN_W-1:0]       w_frac;
    logic [c_W-1:0]         w_final;

    always_comb begin
        w_lzc   = '0;
        w_found = 1'b0;
        for (int i = c_X - 1; i >= 0; i--) begin
            if (!w_found) begin
                if (r_sum[i]) w_found = 1'b1;
                else          w_lzc   = w_lzc + 1'b1;
            end
        end
    end

    always_comb begin
        if (r_sum[c_X]) begin
            w_norm = {r_sum[c_X:2], r_sum[1] | r_sum[0]};
            w_nexp = {2'b00, r_exp} + c_EW'(1);
        end else begin
            w_norm = r_sum[c_X-1:0] << w_lzc;
            w_nexp = {2'b00, r_exp} - {{(c_EW-c_LZ){1'b0}}, w_lzc};
        end
    end

`ifdef FP16_ROUND_NEAREST_EN
    assign w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
`else
    logic w_unused_grs;
    assign w_unused_grs = ^w_norm[2:0];
    assign w_round_up   = 1'b0;
`endif

    // A rounding carry leaves 1.000..0, so the fraction is simply the shifted-down value.
    assign w_rnd  = {1'b0, w_norm[c_X-1:3]} + {{(MAN_W+1){1'b0}}, w_round_up};
    assign w_fexp = w_nexp + {{(c_EW-1){1'b0}}, w_rnd[MAN_W+1]};
    assign w_frac = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];

    always_comb begin
        if (r_special)
            w_final = r_special_val;
        else if (r_sum == '0)
            w_final = '0;
        else if (w_fexp <= c_EXP_ZERO)
            w_final = {r_sign, {(c_W-1){1'b0}}};
        else if (w_fexp >= c_EXP_OVF)
            w_final = {r_sign, c_EXP_INF, {MAN_W{1'b0}}};
        else
            w_final = {r_sign, w_fexp[EXP_W-1:0], w_frac};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (add) w_next = S_ALIGN;
            S_ALIGN:  w_next = S_ADDSUB;
            S_ADDSUB: w_next = S_NORM;
            S_NORM:   w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_big         <= '0;
            r_small       <= '0;
            r_exp         <= '0;
            r_sign        <= 1'b0;
            r_sub         <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_sum         <= '0;
            r_result      <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (add) begin
                        r_a <= number1;
                        r_b <= number2;
                    end
                end
                S_ALIGN: begin
                    r_big         <= {w_big_man, 3'b000};
                    r_small       <= w_small_al;
                    r_exp         <= w_big_exp;
                    r_sign        <= w_swap ? w_b_sign : w_a_sign;
                    r_sub         <= w_a_sign ^ w_b_sign;
                    r_special     <= w_special;
                    r_special_val <= w_special_val;
                end
                S_ADDSUB: r_sum    <= w_sum;
                S_NORM:   r_result <= w_final;
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign ready  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fp16_adder.sv
`default_nettype none
// Bench for fp16_adder: exact-arithmetic reference model, directed and random operands.
module tb_fp16_adder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        add = 1'b0;
    logic [15:0] number1 = '0;
    logic [15:0] number2 = '0;
    logic [15:0] result;
    logic        ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] exp_q[$];
    int          due_q[$];
    logic [15:0] held = '0;

    fp16_adder dut (
        .clk(clk), .reset(reset), .add(add),
        .number1(number1), .number2(number2),
        .result(result), .ready(ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Value in units of 2^-24; exponent 0 counts as zero.
    function automatic longint fval(input logic [15:0] x);
        longint v;
        if (x[14:10] == 5'd0) return 0;
        v = longint'({1'b1, x[9:0]}) << (x[14:10] - 1);
        return x[15] ? -v : v;
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        longint s;
        longint unsigned mag, man;
        int p, e, sh;
        if ((a[14:10] == 5'h1F && a[9:0] != 0) || (b[14:10] == 5'h1F && b[9:0] != 0)) return 16'h7E00;
        if (a[14:10] == 5'h1F && b[14:10] == 5'h1F && a[15] != b[15]) return 16'h7E00;
        if (a[14:10] == 5'h1F) return a;
        if (b[14:10] == 5'h1F) return b;
        if (a[14:10] == 0 && b[14:10] == 0) return (a[15] && b[15]) ? 16'h8000 : 16'h0000;
        s = fval(a) + fval(b);
        if (s == 0) return 16'h0000;
        mag = (s < 0) ? longint'(-s) : longint'(s);
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        e = p - 9;
        sh = 0;
        if (p >= 10) begin
            sh  = p - 10;
            man = mag >> sh;
        end else begin
            man = mag << (10 - p);
        end
`ifdef FP16_ROUND_NEAREST_EN
        if (sh > 0) begin
            longint unsigned rem, half;
            rem  = mag & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && man[0])) man = man + 1;
        end
`endif
        if (man == 2048) begin
            man = 1024;
            e   = e + 1;
        end
        if (e <= 0)  return {s < 0, 15'h0000};
        if (e >= 31) return {s < 0, 5'h1F, 10'h000};
        return {s < 0, e[4:0], man[9:0]};
    endfunction

    // Compare process: ready pulses, latency, result value and result hold.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            due_q.delete();
            held = '0;
            n_tests++;
            if (result !== 16'h0000 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: result=%h ready=%b required result=0000 ready=0", result, ready);
            end
        end else begin
            if (ready === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_ready: cycle %0d result=%h with no operation pending", cyc, result);
                end else begin
                    logic [15:0] e;
                    int d;
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    if (cyc != d || result !== e) begin
                        n_fail++;
                        $display("FAIL op_result: cycle %0d result=%h required %h at cycle %0d", cyc, result, e, d);
                    end
                    held = e;
                end
            end else if (ready !== 1'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL ready_x: ready=%b", ready);
            end
            if (due_q.size() > 0 && cyc > due_q[0]) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_ready: cycle %0d required result %h by cycle %0d", cyc, exp_q[0], due_q[0]);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            n_tests++;
            if (result !== held) begin
                n_fail++;
                $display("FAIL result_hold: cycle %0d result=%h required %h", cyc, result, held);
            end
        end
    end

    task automatic op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk); #1;
        number1 = a;
        number2 = b;
        add = 1'b1;
        exp_q.push_back(ref_add(a, b));
        due_q.push_back(cyc + 4);
        @(negedge clk); #1;
        add = 1'b0;
        number1 = 16'($urandom);
        number2 = 16'($urandom);
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [15:0] rnd_finite();
        logic [15:0] x;
        x = 16'($urandom);
        if (x[14:10] == 5'h1F) x[14] = 1'b0;
        return x;
    endfunction

    logic [15:0] specials[12] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7BFF,
                                  16'hFBFF, 16'h0400, 16'h8400, 16'h0001, 16'h3C00, 16'hBC00};

`ifdef FP16_ROUND_NEAREST_EN
    localparam logic [15:0] ROUND_EXP = 16'h3C02;
`else
    localparam logic [15:0] ROUND_EXP = 16'h3C01;
`endif

    logic [15:0] pin_a[11] = '{16'h4C40, 16'h4C40, 16'h4C80, 16'h4C40, 16'h7BFF, 16'h7C00,
                               16'h7C00, 16'h3C01, 16'h8000, 16'h0000, 16'h7E01};
    logic [15:0] pin_b[11] = '{16'h4C40, 16'h4C80, 16'hCC40, 16'hCC40, 16'h7BFF, 16'hFC00,
                               16'h3C00, 16'h1000, 16'h8000, 16'h8000, 16'h3C00};
    logic [15:0] pin_r[11];

    initial begin
        pin_r = '{16'h5040, 16'h5060, 16'h3C00, 16'h0000, 16'h7C00, 16'h7E00,
                  16'h7C00, ROUND_EXP, 16'h8000, 16'h0000, 16'h7E00};
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            logic [15:0] m;
            m = ref_add(pin_a[i], pin_b[i]);
            n_tests++;
            if (m !== pin_r[i]) begin
                n_fail++;
                $display("FAIL model_pin %0d: %h+%h model=%h required %h", i, pin_a[i], pin_b[i], m, pin_r[i]);
            end
        end

        op(16'h4C40, 16'h4C40);
        op(16'h4C40, 16'h4C80);

        // Eight back-to-back operations with add held high.
        @(negedge clk); #1;
        add = 1'b1;
        for (int i = 0; i < 8; i++) begin
            number1 = 16'h4C40;
            number2 = (i % 2 == 0) ? 16'h4C80 : 16'h4C40;
            exp_q.push_back(ref_add(number1, number2));
            due_q.push_back(cyc + 4);
            if (i < 7) begin
                repeat (5) @(negedge clk);
                #1;
            end
        end
        @(negedge clk); #1;
        add = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) op(pin_a[i], pin_b[i]);

        // add still high while the FSM is in ALIGN must not start a second operation.
        @(negedge clk); #1;
        number1 = 16'h4C80;
        number2 = 16'hCC40;
        add = 1'b1;
        exp_q.push_back(ref_add(number1, number2));
        due_q.push_back(cyc + 4);
        @(negedge clk); #1;
        @(negedge clk); #1;
        add = 1'b0;
        repeat (6) @(negedge clk);

        // Reset while in ADDSUB aborts the operation.
        @(negedge clk); #1;
        number1 = 16'h4C40;
        number2 = 16'h4C80;
        add = 1'b1;
        exp_q.push_back(ref_add(number1, number2));
        due_q.push_back(cyc + 4);
        @(negedge clk); #1;
        add = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        op(16'h4C40, 16'h4C80);

        for (int i = 0; i < 250; i++) begin
            logic [15:0] a, b;
            case ($urandom_range(0, 3))
                0: begin a = 16'($urandom); b = 16'($urandom); end
                1: begin a = rnd_finite(); b = a ^ 16'h8000; b[2:0] = 3'($urandom); end
                2: begin
                    a = rnd_finite();
                    b = {1'($urandom), a[14:0] + 15'($urandom_range(0, 8191)) - 15'd4096};
                end
                default: begin
                    a = specials[$urandom_range(0, 11)];
                    b = ($urandom_range(0, 1) == 1) ? specials[$urandom_range(0, 11)] : rnd_finite();
                end
            endcase
            op(a, b);
        end

        repeat (8) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d operations without ready, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
